// File: rtl/result_drain_reader_pkg.sv
// Shared definitions for the results-SRAM drain reader.
//   - drain_state_t : FSM state encoding (IDLE, FETCH, FLUSH, FIN)
//   - PREFETCH_ENTRIES : fixed depth of the prefetch buffer
//   - lane_width()  : output lane width; DATA_BW when RESULT_CLIP_EN is
//                     defined, otherwise the raw partial-sum width
//   - sat_max()/sat_min() : signed saturation bounds for a given width
// Optional feature macro: RESULT_CLIP_EN
package result_drain_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FLUSH,
        ST_FIN
    } drain_state_t;

    localparam int unsigned PREFETCH_ENTRIES = 2;

    function automatic int unsigned lane_width(input int unsigned psum_bw,
                                               input int unsigned data_bw);
`ifdef RESULT_CLIP_EN
        lane_width = data_bw;
`else
        lane_width = psum_bw;
`endif
    endfunction

    function automatic int sat_max(input int unsigned bw);
        sat_max = (1 << (bw - 1)) - 1;
    endfunction

    function automatic int sat_min(input int unsigned bw);
        sat_min = -(1 << (bw - 1));
    endfunction

endpackage

// File: rtl/result_drain_reader_prefetch_buf.sv
// Two-entry FIFO holding {row, last} between the SRAM read port and the
// output stream.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   push          : write push_row/push_last this cycle
//   pop           : remove head entry this cycle
//   head_row/last : current head entry (zero after reset)
//   count         : number of valid entries (0..2)
module result_prefetch_buf #(
    parameter int unsigned ROW_W = 384
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [ROW_W-1:0] push_row,
    input  logic             push_last,
    input  logic             pop,
    output logic [ROW_W-1:0] head_row,
    output logic             head_last,
    output logic [1:0]       count
);

    logic [ROW_W-1:0] row_q0;
    logic [ROW_W-1:0] row_q1;
    logic [1:0]       last_q;
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != 2'd0);
    // A full buffer may still accept a row when the head leaves the same cycle.
    assign do_push = push && ((count != 2'd2) || do_pop);

    assign head_row  = rd_ptr ? row_q1 : row_q0;
    assign head_last = last_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q0 <= '0;
            row_q1 <= '0;
            last_q <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                if (wr_ptr) row_q1 <= push_row;
                else        row_q0 <= push_row;
                last_q[wr_ptr] <= push_last;
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/result_drain_reader.sv
// Drains result rows from the results SRAM and streams them out over a
// valid/ready interface, one row per beat, bubble-free while m_ready holds.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   start            : begin a drain (ignored while busy)
//   base_addr        : first row address, sampled on accepted start
//   num_rows         : rows to drain (0..2^ADDRESSSIZE)
//   sram_re/sram_addr: read strobe/address; sram_rdata valid one cycle later
//   m_valid/m_ready  : output handshake; m_data lane 0 in LSBs
//   m_last           : final beat of the drain
//   busy             : drain in progress (including the FIN cycle)
//   done             : one-cycle pulse after the last beat is accepted
// Optional feature macro: RESULT_CLIP_EN (signed-saturate lanes to DATA_BW)
module result_drain_reader
    import result_drain_reader_pkg::*;
#(
    parameter int unsigned ADDRESSSIZE    = 10,
    parameter int unsigned MATRIX_SIZE    = 16,
    parameter int unsigned PARTIAL_SUM_BW = 24,
    parameter int unsigned DATA_BW        = 8,
    parameter int unsigned PREFETCH_DEPTH = PREFETCH_ENTRIES
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [ADDRESSSIZE-1:0]                 base_addr,
    input  logic [ADDRESSSIZE:0]                   num_rows,
    output logic                                   sram_re,
    output logic [ADDRESSSIZE-1:0]                 sram_addr,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]  sram_rdata,
    output logic                                   m_valid,
    input  logic                                   m_ready,
    output logic [MATRIX_SIZE*lane_width(PARTIAL_SUM_BW, DATA_BW)-1:0] m_data,
    output logic                                   m_last,
    output logic                                   busy,
    output logic                                   done
);

    localparam int unsigned ROW_W = PARTIAL_SUM_BW * MATRIX_SIZE;

    drain_state_t           state;
    logic [ADDRESSSIZE:0]   reads_left;
    logic                   in_flight;
    logic                   in_flight_last;
    logic [1:0]             occupancy;
    logic [ROW_W-1:0]       head_row;
    logic                   head_last;
    logic                   pop;
    logic [2:0]             committed;
    logic                   last_read;

    assign m_valid = (occupancy != 2'd0);
    assign m_last  = head_last;
    assign pop     = m_valid && m_ready;

    // Rows held plus the row on its way back; a slot freed by this cycle's
    // pop counts as room, which keeps the stream bubble-free.
    assign committed = 3'(occupancy) + 3'(in_flight);
    assign sram_re   = (state == ST_FETCH) && (reads_left != '0) &&
                       (committed < (3'(PREFETCH_DEPTH) + 3'(pop)));
    assign last_read = (reads_left == (ADDRESSSIZE + 1)'(1));

    result_prefetch_buf #(
        .ROW_W (ROW_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (in_flight),
        .push_row  (sram_rdata),
        .push_last (in_flight_last),
        .pop       (pop),
        .head_row  (head_row),
        .head_last (head_last),
        .count     (occupancy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            sram_addr      <= '0;
            reads_left     <= '0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            in_flight      <= sram_re;
            in_flight_last <= sram_re && last_read;
            done           <= 1'b0;

            if (sram_re) begin
                sram_addr  <= sram_addr + ADDRESSSIZE'(1);
                reads_left <= reads_left - (ADDRESSSIZE + 1)'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sram_addr  <= base_addr;
                        reads_left <= num_rows;
                        busy       <= 1'b1;
                        if (num_rows == '0) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (sram_re && last_read) state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (pop && head_last) begin
                        state <= ST_FIN;
                        done  <= 1'b1;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef RESULT_CLIP_EN
    localparam logic signed [PARTIAL_SUM_BW-1:0] LANE_MAX = PARTIAL_SUM_BW'(sat_max(DATA_BW));
    localparam logic signed [PARTIAL_SUM_BW-1:0] LANE_MIN = PARTIAL_SUM_BW'(sat_min(DATA_BW));

    for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_clip
        logic signed [PARTIAL_SUM_BW-1:0] lane;
        assign lane = head_row[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
        assign m_data[i*DATA_BW +: DATA_BW] =
            (lane > LANE_MAX) ? LANE_MAX[DATA_BW-1:0] :
            (lane < LANE_MIN) ? LANE_MIN[DATA_BW-1:0] :
                                lane[DATA_BW-1:0];
    end
`else
    assign m_data = head_row;
`endif

endmodule

// File: tb/tb_result_drain_reader.sv
module tb_result_drain_reader;

    localparam int AW  = 10;
    localparam int MS  = 16;
    localparam int PSW = 24;
    localparam int DBW = 8;
`ifdef RESULT_CLIP_EN
    localparam int LW = DBW;
`else
    localparam int LW = PSW;
`endif
    localparam int IW    = MS * PSW;
    localparam int OW    = MS * LW;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_rows;
    logic          sram_re;
    logic [AW-1:0] sram_addr;
    logic [IW-1:0] sram_rdata;
    logic          m_valid;
    logic          m_ready;
    logic [OW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    result_drain_reader #(
        .ADDRESSSIZE    (AW),
        .MATRIX_SIZE    (MS),
        .PARTIAL_SUM_BW (PSW),
        .DATA_BW        (DBW),
        .PREFETCH_DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .num_rows   (num_rows),
        .sram_re    (sram_re),
        .sram_addr  (sram_addr),
        .sram_rdata (sram_rdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done)
    );

    // SRAM model: one-cycle read latency
    logic [IW-1:0] mem [DEPTH];
    initial sram_rdata = '0;
    always @(posedge clk) if (sram_re) sram_rdata <= mem[sram_addr];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [OW:0]   exp_q[$];
    logic [AW-1:0] addr_q[$];
    int ready_mode = 0;
    int first_valid_cyc = -1;
    int done_cyc = -1;
    int done_count = 0;
    int max_occ = 0;
    int overflow_seen = 0;
    logic          stalled_prev = 1'b0;
    logic [OW-1:0] prev_data;
    logic          prev_last;

    function automatic logic [OW-1:0] exp_row(input int r);
        logic [OW-1:0] v;
        logic signed [PSW-1:0] s;
        v = '0;
        for (int l = 0; l < MS; l++) begin
            s = mem[r][l*PSW +: PSW];
`ifdef RESULT_CLIP_EN
            if (s > 127)       v[l*LW +: LW] = 8'h7F;
            else if (s < -128) v[l*LW +: LW] = 8'h80;
            else               v[l*LW +: LW] = s[7:0];
`else
            v[l*LW +: LW] = s;
`endif
        end
        return v;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [OW:0]   e;
        logic [AW-1:0] ea;
        if (rst) begin
            stalled_prev = 1'b0;
        end else begin
            if (sram_re) begin
                checks++;
                if (addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL read_addr: unexpected read of %0d", sram_addr);
                end else begin
                    ea = addr_q.pop_front();
                    if (sram_addr !== ea) begin
                        errors++;
                        $display("FAIL read_addr: got %0d want %0d", sram_addr, ea);
                    end
                end
            end
            if (stalled_prev) begin
                checks++;
                if (!m_valid || m_data !== prev_data || m_last !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b last=%b want held last=%b", m_valid, m_last, prev_last);
                end
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat: unexpected beat data=%h", m_data);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e[OW-1:0] || m_last !== e[OW]) begin
                        errors++;
                        $display("FAIL beat: got data=%h last=%b want data=%h last=%b", m_data, m_last, e[OW-1:0], e[OW]);
                    end
                end
            end
            stalled_prev = m_valid && !m_ready;
            prev_data    = m_data;
            prev_last    = m_last;
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
            if (int'(dut.u_buf.count) > max_occ) max_occ = int'(dut.u_buf.count);
            if (dut.u_buf.count == 2'd2 && dut.u_buf.push && !dut.u_buf.pop) overflow_seen++;
        end
    end

    // m_ready driver: mode 0 always 1, mode 1 pattern 1,0,0,1, mode 2 always 0
    initial begin
        int phase;
        phase = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: m_ready = 1'b1;
                1: begin
                    m_ready = (phase % 4 == 0) || (phase % 4 == 3);
                    phase++;
                end
                default: m_ready = 1'b0;
            endcase
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_drain(input int base, input int n, input int mode,
                             input bit timing, input bit poke);
        int tstart, d0, budget;
        for (int i = 0; i < n; i++) begin
            int a;
            a = (base + i) % DEPTH;
            addr_q.push_back(AW'(a));
            exp_q.push_back({(i == n - 1), exp_row(a)});
        end
        ready_mode = mode;
        first_valid_cyc = -1;
        d0 = done_count;
        base_addr = AW'(base);
        num_rows = (AW + 1)'(n);
        start = 1'b1;
        tstart = cyc;
        step();
        start = 1'b0;
        budget = n * 8 + 40;
        while (done_count == d0 && budget > 0) begin
            if (poke && cyc == tstart + 3) begin
                start = 1'b1;
                base_addr = AW'(500);
                num_rows = (AW + 1)'(7);
            end else begin
                start = 1'b0;
            end
            step();
            budget--;
        end
        start = 1'b0;
        checks++;
        if (done_count == d0) begin
            errors++;
            $display("FAIL done_timeout: got no done want done within budget (base=%0d n=%0d)", base, n);
        end
        step();
        step();
        check("done_single_pulse", done_count, d0 + 1);
        check("busy_after_done", int'(busy), 0);
        check("beats_left", exp_q.size(), 0);
        check("reads_left", addr_q.size(), 0);
        if (timing) begin
            check("done_latency", done_cyc - tstart, (n == 0) ? 1 : n + 3);
            check("first_valid_latency", (first_valid_cyc < 0) ? -1 : first_valid_cyc - tstart,
                  (n == 0) ? -1 : 3);
        end
        exp_q.delete();
        addr_q.delete();
    endtask

    initial begin
        int d0, tstart;
        for (int r = 0; r < DEPTH; r++)
            for (int l = 0; l < MS; l++)
                mem[r][l*PSW +: PSW] = PSW'(r * 16 + l);
        mem[200][0*PSW +: PSW] = 24'h000200;
        mem[200][1*PSW +: PSW] = 24'hFFFE00;
        mem[200][2*PSW +: PSW] = 24'h00007F;

        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        num_rows = '0;
        repeat (3) step();
        check("rst_sram_re", int'(sram_re), 0);
        check("rst_sram_addr", int'(sram_addr), 0);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_data_zero", int'(m_data == '0), 1);
        check("rst_m_last", int'(m_last), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b0;
        step();

        // full-rate drain with an ignored start while busy
        run_drain(0, 16, 0, 1'b1, 1'b1);
        // same drain with back-pressure
        run_drain(0, 16, 1, 1'b0, 1'b0);
        // address wrap
        run_drain(1022, 4, 0, 1'b1, 1'b0);
        // empty drain
        run_drain(0, 0, 0, 1'b1, 1'b0);

        // reset mid-drain with the consumer stalled
        ready_mode = 2;
        addr_q.push_back(AW'(0));
        addr_q.push_back(AW'(1));
        d0 = done_count;
        base_addr = '0;
        num_rows = (AW + 1)'(16);
        start = 1'b1;
        tstart = cyc;
        step();
        start = 1'b0;
        step();
        step();
        check("midrst_reads_seen", addr_q.size(), 0);
        rst = 1'b1;
        step();
        check("midrst_sram_re", int'(sram_re), 0);
        check("midrst_sram_addr", int'(sram_addr), 0);
        check("midrst_m_valid", int'(m_valid), 0);
        check("midrst_m_data_zero", int'(m_data == '0), 1);
        check("midrst_m_last", int'(m_last), 0);
        check("midrst_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (4) step();
        check("midrst_no_done", done_count, d0);
        check("midrst_still_idle", int'(m_valid), 0);
        addr_q.delete();
        exp_q.delete();
        run_drain(100, 5, 0, 1'b1, 1'b0);

        // saturation row, single-row drain, stalled then full-rate
        run_drain(200, 1, 1, 1'b0, 1'b0);
        run_drain(200, 3, 0, 1'b1, 1'b0);
`ifdef RESULT_CLIP_EN
        check("clip_max_const", int'(exp_row(200) >> 0 & 8'hFF), 127);
`endif

        // every address once, starting mid-array
        run_drain(512, 1024, 0, 1'b1, 1'b0);

        check("max_occupancy_le_2", int'(max_occ <= 2), 1);
        check("no_overflow", overflow_seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
